// File: rtl/alu_pkg.sv
// Shared types, frame constants and CRC helpers for the serial ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        AND_OP = 3'b000,
        OR_OP  = 3'b001,
        ADD_OP = 3'b100,
        SUB_OP = 3'b101
    } op_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CMD  = 1'b1;
    localparam int   FRAME_LEN = 11;

    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    // x^4+x+1, init 0, MSB first
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    // x^3+x+1, init 0, MSB first
    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'h0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    function automatic logic [FRAME_LEN-1:0] make_frame(input logic typ, input logic [7:0] pay);
        return {START_BIT, typ, pay, STOP_BIT};
    endfunction

    function automatic logic [7:0] err_payload(input logic [2:0] e);
        return {1'b1, e, e, ^{1'b1, e, e}};
    endfunction

endpackage

// File: rtl/mtm_alu_serializer.sv
// Shifts up to five pre-built 11-bit frames out MSB first, back-to-back; first bit
// appears on the edge that samples i_load. sout idles high; o_busy covers the whole burst.
module mtm_alu_serializer
    import alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic [2:0]             i_nframes,
    input  logic [5*FRAME_LEN-1:0] i_frames,
    output logic                   o_busy,
    output logic                   o_sout
);
    localparam int W = 5 * FRAME_LEN;

    typedef enum logic {TX_IDLE, TX_FRAME} tx_state_e;

    tx_state_e      r_state, w_next;
    logic [W-1:0]   r_shift;
    logic [5:0]     r_left;
    logic           r_sout;
    logic [5:0]     w_nbits;

    assign w_nbits = 6'(i_nframes) * 6'(FRAME_LEN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            TX_IDLE:  if (i_load) w_next = TX_FRAME;
            TX_FRAME: if (r_left == 6'd0) w_next = TX_IDLE;
            default:  w_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= TX_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_left  <= '0;
            r_sout  <= 1'b1;
        end else if (r_state == TX_IDLE) begin
            if (i_load) begin
                r_sout  <= i_frames[W-1];
                r_shift <= {i_frames[W-2:0], 1'b1};
                r_left  <= w_nbits - 6'd1;
            end
        end else if (r_left != 6'd0) begin
            r_sout  <= r_shift[W-1];
            r_shift <= {r_shift[W-2:0], 1'b1};
            r_left  <= r_left - 6'd1;
        end else begin
            r_sout <= 1'b1;
        end
    end

    assign o_busy = (r_state == TX_FRAME);
    assign o_sout = r_sout;

endmodule

// File: rtl/mtm_alu.sv
// Serial 32-bit ALU: deserialises 9 input frames, checks framing/CRC/opcode, answers with
// 5 result frames or 1 error frame starting 2 edges after the CMD stop bit; sin ignored while answering.
module mtm_alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sin,
    output logic sout
);
    localparam int RESP_W = 5 * FRAME_LEN;

    typedef enum logic [2:0] {IDLE, RX_FRAME, CHECK, PROCESS, TX_WAIT, WAIT_IDLE} rx_state_e;

    rx_state_e         r_state, w_next;
    logic [3:0]        r_bit_cnt, r_data_cnt;
    logic [9:0]        r_rx;
    logic [63:0]       r_ops;
    logic [RESP_W-1:0] r_frames, w_frames;
    logic [2:0]        r_nframes, w_nframes;
    logic              r_wait_idle;

    logic              w_type, w_stop_bad, w_resp, w_load, w_busy, w_valid_op;
    logic [7:0]        w_pay;
    logic [2:0]        w_op, w_err;
    logic [31:0]       w_b, w_a, w_res;
    logic [32:0]       w_sum;
    flags_t            w_flags;

    // r_rx holds {type, payload[7:0], stop} of the frame just received
    assign w_type     = r_rx[9];
    assign w_pay      = r_rx[8:1];
    assign w_stop_bad = (r_rx[0] != STOP_BIT);
    assign w_resp     = w_stop_bad || (w_type == TYPE_CMD);
    assign w_op       = w_pay[6:4];
    assign w_b        = r_ops[63:32];
    assign w_a        = r_ops[31:0];

    always_comb begin
        w_res      = '0;
        w_sum      = '0;
        w_flags    = '0;
        w_valid_op = 1'b1;
        case (op_e'(w_op))
            AND_OP: w_res = w_b & w_a;
            OR_OP:  w_res = w_b | w_a;
            ADD_OP: begin
                w_sum         = {1'b0, w_b} + {1'b0, w_a};
                w_res         = w_sum[31:0];
                w_flags.carry = w_sum[32];
                w_flags.ovf   = (w_b[31] == w_a[31]) && (w_res[31] != w_b[31]);
            end
            SUB_OP: begin
                w_res         = w_b - w_a;
                w_flags.carry = (w_b < w_a);
                w_flags.ovf   = (w_b[31] != w_a[31]) && (w_res[31] != w_b[31]);
            end
            default: w_valid_op = 1'b0;
        endcase
        w_flags.zero = (w_res == 32'd0);
        w_flags.neg  = w_res[31];
    end

    always_comb begin
        w_err     = '0;
        w_frames  = '1;
        w_nframes = 3'd5;
        if (w_stop_bad || r_data_cnt != 4'd8)
            w_err[ERR_DATA_BIT] = 1'b1;
        else if (crc4({w_b, w_a, 1'b1, w_op}) != w_pay[3:0])
            w_err[ERR_CRC_BIT] = 1'b1;
        else if (!w_valid_op)
            w_err[ERR_OP_BIT] = 1'b1;

        if (|w_err) begin
            w_frames  = {make_frame(TYPE_CMD, err_payload(w_err)), {(4*FRAME_LEN){1'b1}}};
            w_nframes = 3'd1;
        end else begin
            w_frames = {make_frame(TYPE_DATA, w_res[31:24]), make_frame(TYPE_DATA, w_res[23:16]),
                        make_frame(TYPE_DATA, w_res[15:8]),  make_frame(TYPE_DATA, w_res[7:0]),
                        make_frame(TYPE_CMD, {1'b0, w_flags, crc3({w_res, 1'b0, w_flags})})};
        end
    end

    // CHECK also accepts a start bit so input frames may arrive back-to-back
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE:      if (sin == START_BIT) w_next = RX_FRAME;
            RX_FRAME:  if (r_bit_cnt == 4'd9) w_next = CHECK;
            CHECK: begin
                if (w_resp)                 w_next = PROCESS;
                else if (sin == START_BIT)  w_next = RX_FRAME;
                else                        w_next = IDLE;
            end
            PROCESS: begin
                w_load = 1'b1;
                w_next = TX_WAIT;
            end
            TX_WAIT:   if (!w_busy) w_next = r_wait_idle ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (sin == STOP_BIT) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_data_cnt  <= '0;
            r_rx        <= '0;
            r_ops       <= '0;
            r_frames    <= '1;
            r_nframes   <= '0;
            r_wait_idle <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_bit_cnt <= '0;
                RX_FRAME: begin
                    r_rx      <= {r_rx[8:0], sin};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                CHECK: begin
                    r_bit_cnt <= '0;
                    if (w_resp) begin
                        r_frames    <= w_frames;
                        r_nframes   <= w_nframes;
                        r_data_cnt  <= '0;
                        r_wait_idle <= w_stop_bad;
                    end else begin
                        r_ops <= {r_ops[55:0], w_pay};
                        // saturates at 9 so an over-long run stays flagged until the CMD frame
                        if (r_data_cnt != 4'd9) r_data_cnt <= r_data_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    mtm_alu_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_nframes (r_nframes),
        .i_frames  (r_frames),
        .o_busy    (w_busy),
        .o_sout    (sout)
    );

endmodule

// File: tb/tb_mtm_alu.sv
// Randomised and directed bench for mtm_alu against a behavioural packet-level model.
module tb_mtm_alu;

    logic clk = 1'b0;
    logic rst_n;
    logic sin;
    logic sout;

    always #5 clk = ~clk;

    mtm_alu dut (.clk(clk), .rst_n(rst_n), .sin(sin), .sout(sout));

    int vectors     = 0;
    int miscompares = 0;

    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];
    int          got_lat;
    logic        got_idle;

    localparam logic [31:0] DIR_B  [5] = '{32'h0F0F0F0F, 32'h00000001, 32'h7FFFFFFF, 32'h00000000, 32'h000000A0};
    localparam logic [31:0] DIR_A  [5] = '{32'hFFFF0000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h00000005};
    localparam logic [2:0]  DIR_OP [5] = '{3'b000, 3'b100, 3'b100, 3'b101, 3'b001};
    localparam logic [31:0] DIR_C  [5] = '{32'h0F0F0000, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h000000A5};
    localparam logic [3:0]  DIR_F  [5] = '{4'b0000, 4'b1010, 4'b0101, 4'b1001, 4'b0000};

    localparam int          ERR_N   [6] = '{7, 8, 8, 9, 8, 7};
    localparam bit          ERR_BAD [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [2:0]  ERR_OPC [6] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b111, 3'b011};
    localparam logic [7:0]  ERR_PAY [6] = '{8'hC9, 8'hA5, 8'h93, 8'hC9, 8'hA5, 8'hC9};

    // CRCs as remainders of polynomial long division over GF(2)
    function automatic logic [3:0] ref_crc4(input logic [67:0] msg);
        logic [71:0] v;
        v = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    function automatic logic [2:0] ref_crc3(input logic [36:0] msg);
        logic [39:0] v;
        v = {msg, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        return v[2:0];
    endfunction

    function automatic logic [10:0] mk(input logic t, input logic [7:0] p);
        return {1'b0, t, p, 1'b1};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000 | 32'($urandom_range(0, 3));
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                         input logic [3:0] crc_sent, input int ndata);
        logic [2:0]  e;
        logic [31:0] c;
        logic [3:0]  fl;
        logic [63:0] u;
        longint      s, sc, sb, sa;
        exp_q.delete();
        e = 3'b000; c = '0; u = '0; s = 0;
        if (ndata != 8)                                     e = 3'b100;
        else if (crc_sent != ref_crc4({b, a, 1'b1, op}))    e = 3'b010;
        else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e = 3'b001;
        if (e != 3'b000) begin
            exp_q.push_back(mk(1'b1, {1'b1, e, e, 1'($countones({1'b1, e, e}) % 2)}));
            return;
        end
        sb = $signed(b);
        sa = $signed(a);
        case (op)
            3'b000:  c = b & a;
            3'b001:  c = b | a;
            3'b100:  begin u = 64'(b) + 64'(a); c = u[31:0]; s = sb + sa; end
            default: begin c = b - a; s = sb - sa; end
        endcase
        sc = $signed(c);
        fl[3] = (op == 3'b100) ? (u > 64'hFFFFFFFF) : (op == 3'b101) ? (b < a) : 1'b0;
        fl[2] = op[2] && (s != sc);
        fl[1] = (c == 32'd0);
        fl[0] = c[31];
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, c[31-8*k -: 8]));
        exp_q.push_back(mk(1'b1, {1'b0, fl, ref_crc3({c, 1'b0, fl})}));
    endtask

    task automatic send_frame(input logic t, input logic [7:0] p, input logic stop, input int gap);
        logic [10:0] f;
        f = {1'b0, t, p, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = f[i];
        end
        repeat (gap) begin
            @(negedge clk);
            sin = 1'b1;
        end
    endtask

    task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                               input logic [3:0] crc_sent, input int ndata, input int maxgap);
        logic [63:0] ops;
        logic [7:0]  by;
        ops = {b, a};
        repeat (2) begin
            @(negedge clk);
            sin = 1'b1;
        end
        for (int i = 0; i < ndata; i++) begin
            by = (i < 8) ? ops[63-8*i -: 8] : 8'h5A;
            send_frame(1'b0, by, 1'b1, int'($urandom_range(maxgap, 0)));
        end
        send_frame(1'b1, {1'b0, op, crc_sent}, 1'b1, 0);
    endtask

    // Called right after the CMD stop bit has been driven; latency counted in cycles.
    task automatic capture(input logic hold);
        logic [10:0] fr;
        got_q.delete();
        got_lat  = -1;
        got_idle = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            sin = hold;
            if (sout === 1'b0) begin
                got_lat = k;
                break;
            end
        end
        if (got_lat < 0) return;
        for (int f = 0; f < 5; f++) begin
            if (f > 0) @(negedge clk);
            fr[10] = sout;
            for (int b = 9; b >= 0; b--) begin
                @(negedge clk);
                fr[b] = sout;
            end
            got_q.push_back(fr);
            if (fr[9] !== 1'b0) break;
        end
        @(negedge clk);
        got_idle = sout;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (sout !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_sout: got %b want 1", sout);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (sout !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_idle: %0d non-idle cycles, want 0", bad);
        end
    endtask

    task automatic test_alu_directed();
        logic [31:0] c;
        logic [3:0]  f;
        logic [10:0] t;
        logic [3:0]  crc;
        for (int i = 0; i < 5; i++) begin
            crc = ref_crc4({DIR_B[i], DIR_A[i], 1'b1, DIR_OP[i]});
            model(DIR_B[i], DIR_A[i], DIR_OP[i], crc, 8);
            send_packet(DIR_B[i], DIR_A[i], DIR_OP[i], crc, 8, 0);
            capture(1'b1);
            vectors++;
            if (got_lat !== 3) begin
                miscompares++;
                $display("FAIL dir%0d_latency: got %0d want 3", i, got_lat);
            end
            vectors++;
            if (got_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL dir%0d_nframes: got %0d want %0d", i, got_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    vectors++;
                    if (got_q[k] !== exp_q[k]) begin
                        miscompares++;
                        $display("FAIL dir%0d_frame%0d: got %b want %b", i, k, got_q[k], exp_q[k]);
                    end
                end
            end
            c = 'x;
            f = 'x;
            if (got_q.size() == 5) begin
                for (int k = 0; k < 4; k++) begin
                    t = got_q[k];
                    c = {c[23:0], t[8:1]};
                end
                t = got_q[4];
                f = t[7:4];
            end
            vectors++;
            if (c !== DIR_C[i]) begin
                miscompares++;
                $display("FAIL dir%0d_result: got %h want %h", i, c, DIR_C[i]);
            end
            vectors++;
            if (f !== DIR_F[i]) begin
                miscompares++;
                $display("FAIL dir%0d_flags: got %b want %b", i, f, DIR_F[i]);
            end
            vectors++;
            if (got_idle !== 1'b1) begin
                miscompares++;
                $display("FAIL dir%0d_idle: got %b want 1", i, got_idle);
            end
        end
    endtask

    task automatic test_errors();
        logic [3:0]  crc;
        logic [31:0] b, a;
        logic [10:0] t;
        for (int i = 0; i < 6; i++) begin
            b   = $urandom;
            a   = $urandom;
            crc = ref_crc4({b, a, 1'b1, ERR_OPC[i]}) ^ (ERR_BAD[i] ? 4'h5 : 4'h0);
            model(b, a, ERR_OPC[i], crc, ERR_N[i]);
            send_packet(b, a, ERR_OPC[i], crc, ERR_N[i], 1);
            capture(1'b1);
            vectors++;
            if (got_lat !== 3) begin
                miscompares++;
                $display("FAIL err%0d_latency: got %0d want 3", i, got_lat);
            end
            vectors++;
            if (got_q.size() != 1) begin
                miscompares++;
                $display("FAIL err%0d_nframes: got %0d want 1", i, got_q.size());
            end else begin
                t = got_q[0];
                vectors++;
                if (t !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL err%0d_frame: got %b want %b", i, t, exp_q[0]);
                end
                vectors++;
                if (t[8:1] !== ERR_PAY[i] || t[9] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL err%0d_payload: got type %b pay %h want type 1 pay %h", i, t[9], t[8:1], ERR_PAY[i]);
                end
            end
        end
    endtask

    task automatic test_bad_stop();
        int          bad;
        logic [31:0] b, a;
        logic [3:0]  crc;
        repeat (2) @(negedge clk);
        send_frame(1'b0, 8'h11, 1'b1, 0);
        send_frame(1'b0, 8'h22, 1'b1, 0);
        send_frame(1'b0, 8'h33, 1'b0, 0);
        capture(1'b0);
        vectors++;
        if (got_lat !== 3) begin
            miscompares++;
            $display("FAIL stop_latency: got %0d want 3", got_lat);
        end
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== mk(1'b1, 8'hC9)) begin
            miscompares++;
            $display("FAIL stop_frame: got %0d frames, first %b want 1 frame %b",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'bx, mk(1'b1, 8'hC9));
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            sin = 1'b0;
            if (sout !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stop_wait_idle: %0d non-idle cycles while sin low, want 0", bad);
        end
        b = pick_operand();
        a = pick_operand();
        crc = ref_crc4({b, a, 1'b1, 3'b101});
        model(b, a, 3'b101, crc, 8);
        send_packet(b, a, 3'b101, crc, 8, 0);
        capture(1'b1);
        vectors++;
        if (got_q != exp_q) begin
            miscompares++;
            $display("FAIL stop_recover: got %0d frames want %0d (b=%h a=%h)", got_q.size(), exp_q.size(), b, a);
        end
    endtask

    task automatic test_random();
        logic [31:0] b, a;
        logic [2:0]  op;
        logic [3:0]  crc;
        int          nd;
        localparam logic [2:0] VALID [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
        for (int i = 0; i < 25; i++) begin
            b  = pick_operand();
            a  = pick_operand();
            op = ($urandom_range(0, 3) != 0) ? VALID[$urandom_range(0, 3)] : 3'($urandom);
            crc = ref_crc4({b, a, 1'b1, op});
            if ($urandom_range(0, 7) == 0) crc = crc ^ 4'($urandom_range(1, 15));
            nd = 8;
            if ($urandom_range(0, 9) == 0) nd = ($urandom_range(0, 1) != 0) ? 9 : 7;
            model(b, a, op, crc, nd);
            send_packet(b, a, op, crc, nd, 2);
            capture(1'b1);
            vectors++;
            if (got_lat !== 3) begin
                miscompares++;
                $display("FAIL rnd%0d_latency: got %0d want 3", i, got_lat);
            end
            vectors++;
            if (got_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL rnd%0d_nframes: got %0d want %0d", i, got_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    vectors++;
                    if (got_q[k] !== exp_q[k]) begin
                        miscompares++;
                        $display("FAIL rnd%0d_frame%0d: got %b want %b (b=%h a=%h op=%b nd=%0d)",
                                 i, k, got_q[k], exp_q[k], b, a, op, nd);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_response();
        logic        found;
        int          bad;
        logic [31:0] c;
        logic [3:0]  f;
        logic [10:0] t;
        send_packet(32'h0, 32'h0, 3'b100, ref_crc4({64'h0, 1'b1, 3'b100}), 8, 0);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            sin = 1'b1;
            if (sout === 1'b0) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rstmid_start: got no start bit, want one within 40 cycles");
        end
        repeat (2 * 11 + 5) @(negedge clk);
        vectors++;
        if (sout !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_databit: got %b want 0", sout);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (sout !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_sout: got %b want 1", sout);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (70) begin
            @(negedge clk);
            if (sout !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rstmid_no_partial: %0d non-idle cycles, want 0", bad);
        end
        model(32'hA0, 32'h05, 3'b001, ref_crc4({32'hA0, 32'h05, 1'b1, 3'b001}), 8);
        send_packet(32'hA0, 32'h05, 3'b001, ref_crc4({32'hA0, 32'h05, 1'b1, 3'b001}), 8, 0);
        capture(1'b1);
        vectors++;
        if (got_q != exp_q) begin
            miscompares++;
            $display("FAIL rstmid_or_frames: got %0d frames want %0d", got_q.size(), exp_q.size());
        end
        c = 'x;
        f = 'x;
        if (got_q.size() == 5) begin
            for (int k = 0; k < 4; k++) begin
                t = got_q[k];
                c = {c[23:0], t[8:1]};
            end
            t = got_q[4];
            f = t[7:4];
        end
        vectors++;
        if (c !== 32'h000000A5 || f !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_or_result: got C=%h F=%b want C=000000a5 F=0000", c, f);
        end
    endtask

    initial begin
        sin   = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_alu_directed();
        test_errors();
        test_bad_stop();
        test_random();
        test_reset_mid_response();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mtm_alu.md
Name: mtm_alu

Overview:
- 32-bit serial-interface ALU.
- Receives two operands and an opcode as 11-bit frames on a single serial input line, checks framing, CRC and opcode.
- Returns either a 32-bit result plus flags, or a single error frame, on a single serial output line.
- Top-level DUT; the bench drives it through the alu_bfm interface (clk, rst_n, sin, sout).

Parameters:
- none (all widths fixed: 32-bit operands, 11-bit frames).

Ports:
- clk  input  1  posedge clock, one serial bit per cycle
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial data input; idle level 1
- sout  output  1  serial data output; idle level 1

Behaviour:
- Frame format, MSB first, one bit per clk posedge, sampled on posedge:
  - bit 0: start = 0
  - bit 1: type (0 = DATA, 1 = CMD)
  - 8 payload bits
  - stop = 1
- Input packet:
  - 8 DATA frames carrying B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] … A[7:0].
  - Then 1 CMD frame with payload {1'b0, OP[2:0], CRC4[3:0]}.
- Opcodes (C is the 32-bit result):
  - AND = 000: C = B & A
  - OR = 001: C = B | A
  - ADD = 100: C = B + A
  - SUB = 101: C = B - A
  - all other opcodes are invalid.
- CRC4:
  - polynomial x^4+x+1, initial value 0.
  - Computed over the 68-bit vector {B, A, 1'b1, OP}, MSB first.
- Flags[3:0] = {Carry, Overflow, Zero, Negative}:
  - Carry: carry-out for ADD; borrow (B<A unsigned) for SUB; 0 for logic ops.
  - Overflow: signed overflow for ADD/SUB; 0 for logic ops.
  - Zero: C == 0.
  - Negative: C[31].
- Success response, 5 frames:
  - 4 DATA frames: C[31:24] … C[7:0].
  - 1 CMD frame with payload {1'b0, FLAGS[3:0], CRC3[2:0]}.
  - CRC3: polynomial x^3+x+1, init 0, over the 37-bit vector {C, 1'b0, FLAGS}.
- Error response, 1 CMD frame:
  - Payload {1'b1, ERR[5:0], PARITY}.
  - ERR = {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}.
  - PARITY makes the 7 bits {1'b1, ERR} even parity.
- Error priority (exactly one error reported): ERR_DATA > ERR_CRC > ERR_OP.
  - ERR_DATA: CMD frame arrives after a DATA count other than 8, more than 8 DATA frames arrive, or any frame has stop bit 0.
  - ERR_CRC: received CRC4 mismatches.
  - ERR_OP: opcode invalid.
- Error recovery:
  - ERR_DATA from an over-long or malformed sequence is emitted at the next CMD frame.
  - For a bad stop bit, the response is emitted right after the offending frame, then the block waits for sin idle 1.
- Latency and output line:
  - First response start bit is driven on the 2nd posedge after the CMD stop bit is sampled.
  - Frames are sent back-to-back with no idle gap.
  - sout = 1 whenever not transmitting.
- Input during transmission is ignored; the next packet may start after the response completes.
- Receiver FSM: IDLE (wait sin=0) -> RX_FRAME (10 bits) -> CHECK -> IDLE or PROCESS.
- Transmitter FSM: TX_IDLE -> TX_FRAME × N -> TX_IDLE.
- Reset: asynchronous on rst_n=0.
  - sout=1, FSMs to IDLE, frame counter 0, operand/CRC registers 0.
  - Reset mid-packet or mid-response aborts it; no partial output follows.

Decomposition:
- Shared package alu_pkg:
  - operation enum (AND_OP, OR_OP, ADD_OP, SUB_OP)
  - flags struct
  - frame constants: START, STOP, DATA/CMD type bits, frame length 11
  - CRC4/CRC3 functions
  - error bit positions
- One natural sub-module: mtm_alu_serializer (loads up to 5 frames, shifts out on sout).
- Deserializer, checks and ALU core stay in the top module.

Test Plan:
- AND: B=0x0F0F0F0F, A=0xFFFF0000, valid CRC -> C=0x0F0F0000, FLAGS=0000, correct CRC3.
- ADD carry/zero: B=0x00000001, A=0xFFFFFFFF -> C=0x00000000, FLAGS=1010.
- ADD overflow: B=A=0x7FFFFFFF -> C=0xFFFFFFFE, FLAGS=0101.
- SUB borrow: B=0, A=1 -> C=0xFFFFFFFF, FLAGS=1001.
- Errors, each giving a single frame:
  - only 7 DATA frames, then CMD -> payload 1_100100_1
  - wrong CRC4 -> 1_010010_1
  - OP=010 with good CRC -> 1_001001_1
- Reset: assert rst_n=0 mid-way through the 3rd output frame -> sout=1 immediately; a following valid OR packet (B=0xA0, A=0x05) -> C=0x000000A5, FLAGS=0000.
